td4_run_ctrl: RTL

TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

---
 rtl/td4_pkg.sv | 34 +++
 rtl/td4_run_ctrl_if.sv | 30 +++
 rtl/td4_ce_prescaler.sv | 30 +++
 rtl/td4_run_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared TD4 run-controller definitions: state encoding, JMP opcode, speed->period table.
// Combinational only; no latency or backpressure of its own.
package td4_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int ADDR_W     = 4;

  localparam logic [3:0] OP_JMP = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  // Period minus one, so the 6-bit prescaler can express the 64-cycle setting.
  function automatic logic [5:0] speed_period_m1(input logic [1:0] speed);
    logic [5:0] p;
    case (speed)
      2'd0:    p = 6'd0;
      2'd1:    p = 6'd3;
      2'd2:    p = 6'd15;
      default: p = 6'd63;
    endcase
    return p;
  endfunction

  function automatic logic is_jmp_self(input logic [7:0] instr, input logic [3:0] pc);
    return (instr[7:4] == OP_JMP) && (instr[3:0] == pc);
  endfunction

endpackage

// File: rtl/td4_run_ctrl_if.sv
// Bundle of load, run-control, core-status and ROM-write signals around the TD4 run controller.
// Pure wiring: no latency; ld_valid/ld_ready is the only handshake.
interface td4_run_ctrl_if;
  logic       load_req;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       run_req;
  logic       step_req;
  logic [1:0] speed;
  logic [3:0] cpu_pc;
  logic [7:0] cpu_instr;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_ce;
  logic       cpu_rst_n;
  logic [2:0] state;
  logic       halted;

  modport master (
    output load_req, ld_valid, ld_data, run_req, step_req, speed, cpu_pc, cpu_instr,
    input  ld_ready, mem_we, mem_addr, mem_wdata, cpu_ce, cpu_rst_n, state, halted
  );

  modport slave (
    input  load_req, ld_valid, ld_data, run_req, step_req, speed, cpu_pc, cpu_instr,
    output ld_ready, mem_we, mem_addr, mem_wdata, cpu_ce, cpu_rst_n, state, halted
  );
endinterface

// File: rtl/td4_ce_prescaler.sv
// Free-running clock-enable divider: tick on the cycle the count reaches period_m1, then wraps.
// First tick period_m1+1 enabled cycles after clr; no backpressure.
module td4_ce_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [5:0] period_m1,
  output logic       tick
);

  logic [5:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == period_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? 6'd0 : cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: program load into ROM, free-run with prescaled cpu_ce, single step, halt on JMP-to-self.
// ROM write lands one cycle after beat acceptance; ld_ready is high for every LOAD cycle.
module td4_run_ctrl
  import td4_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  td4_run_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [5:0]  per_q, per_d;
  logic        step_prev_q, step_prev_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;

  logic ld_ready;
  logic accept;
  logic halt_hit;
  logic step_rise;
  logic tick;
  logic cpu_ce;
  logic presc_clr;

  assign ld_ready  = (state_q == ST_LOAD);
  assign accept    = bus.ld_valid && ld_ready;
  assign halt_hit  = is_jmp_self(bus.cpu_instr, bus.cpu_pc);
  assign step_rise = bus.step_req && !step_prev_q;
  assign presc_clr = (state_d == ST_RUN) && (state_q != ST_RUN);

  td4_ce_prescaler u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == ST_RUN),
    .clr       (presc_clr),
    .period_m1 (per_q),
    .tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    per_d       = per_q;
    cpu_ce      = 1'b0;
    mem_we_d    = accept;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    step_prev_d = bus.step_req;

    if (accept) begin
      mem_addr_d  = addr_q;
      mem_wdata_d = bus.ld_data;
      addr_d      = addr_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.load_req) begin
          state_d = ST_LOAD;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
          per_d   = speed_period_m1(bus.speed);
        end else if (step_rise) begin
          state_d = ST_STEP;
        end
      end
      ST_LOAD: begin
        if ((accept && (addr_q == ADDR_W'(PROG_DEPTH - 1))) || !bus.load_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Exits are checked first so an abort or stop never lets a due pulse through.
        if (bus.load_req) begin
          state_d = ST_LOAD;
        end else if (!bus.run_req) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (halt_hit) state_d = ST_HALT;
          else          cpu_ce  = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_d = ST_HALT;
        end else begin
          cpu_ce  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (bus.load_req) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      addr_d = '0;
    end

    cpu_rst_n_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      per_q       <= '0;
      step_prev_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      per_q       <= per_d;
      step_prev_q <= step_prev_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign bus.ld_ready  = ld_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ce    = cpu_ce;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.state     = state_q;
  assign bus.halted    = (state_q == ST_HALT);

endmodule
